rggen_register_access_arbiter: RTL and testbench
================================================

// Module: rggen_register_access_arbiter
// PURPOSE
//  Shares one register-block access port (valid/access/address/write_data/strobe ->
//  ready/status/read_data) among N host requesters. Round-robin grant, held until the
//  register block responds. Bounded-latency timeout returns SLVERR so a hung block can't stall hosts.
//  Sits between host bus adapters and the register block's common register bus.
// PARAMETERS
//  REQUESTERS      2       number of host ports (>=1; 1 = pass-through with timeout only)
//  ADDRESS_WIDTH   8       register bus address width
//  BUS_WIDTH       32      register bus data width (multiple of 8)
//  TIMEOUT_CYCLES  0       BUSY cycles before forced SLVERR; 0 = timeout disabled
// PORTS
//  i_clk                  in   1                clock
//  i_rst                  in   1                reset, synchronous, active-high
//  i_valid                in   N                per-requester request valid
//  i_access               in   2*N              per-requester access type, bit0 = write
//  i_address              in   N*ADDRESS_WIDTH  per-requester address
//  i_write_data           in   N*BUS_WIDTH      per-requester write data
//  i_strobe               in   N*BUS_WIDTH      per-requester bit strobe
//  o_ready                out  N                per-requester response valid (one-hot or 0)
//  o_status               out  2*N              per-requester response status
//  o_read_data            out  N*BUS_WIDTH      per-requester read data
//  o_register_valid       out  1                downstream request valid
//  o_register_access      out  2                downstream access type
//  o_register_address     out  ADDRESS_WIDTH    downstream address
//  o_register_write_data  out  BUS_WIDTH        downstream write data
//  o_register_strobe      out  BUS_WIDTH        downstream strobe
//  i_register_ready       in   1                downstream response valid
//  i_register_status      in   2                downstream status
//  i_register_read_data   in   BUS_WIDTH        downstream read data
// BEHAVIOUR
//  - Clock i_clk, single domain; reset synchronous, active-high on i_rst. Reset: state IDLE,
//    grant index 0, RR pointer 0, timeout count 0, o_ready=0, o_register_valid=0.
//  - Protocol: requester holds valid and payload stable until its o_ready pulse.
//  - IDLE: if |i_valid, pick first set bit at or after RR pointer (wrap at N-1 -> 0);
//    register grant index, go BUSY next cycle. No request -> stay IDLE. No ready in IDLE.
//  - BUSY: o_register_valid=1; payload muxed combinationally from granted requester.
//    i_register_ready=1 -> same cycle o_ready[g]=1, o_status[g]=i_register_status,
//    o_read_data[g]=i_register_read_data; next: IDLE, RR pointer = (g+1) mod N.
//  - Latency: request->downstream valid 1 cycle; downstream ready->host ready 0 cycles.
//  - Back-to-back: after response, at least one IDLE cycle before next grant (min 2-cycle access).
//  - Timeout (TIMEOUT_CYCLES>0): counter clears on BUSY entry, increments each BUSY cycle;
//    when count==TIMEOUT_CYCLES-1 and no ready: o_ready[g]=1, status 2'b10 (SLVERR),
//    read data 0, o_register_valid still 1 that cycle; next IDLE, pointer advances.
//    Ready and timeout same cycle -> downstream response wins.
//  - Non-granted ports: o_ready=0, o_status=0, o_read_data=0 always.
//  - Granted requester dropping valid in BUSY: protocol violation; arbiter keeps BUSY,
//    still exits via ready or timeout (no deadlock when timeout enabled).
//  - Reset asserted in BUSY: next cycle IDLE, no response issued, pointer 0.
//  - Counter width = clog2(TIMEOUT_CYCLES+1); no wrap possible.
// STRUCTURE
//  - Status codes (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) in shared
//    rggen_rtl_macros.vh; no local literals.
//  - Sub-module rggen_round_robin_arbiter (request vector + pointer -> one-hot grant,
//    index) reused by other shared resources. Payload mux via existing rggen_mux.
//  - State in this module: 1-bit FSM, grant index, RR pointer, timeout counter.
// TESTING
//  1 N=2, req0 write addr 0x04 data 0xA5A5A5A5, ready 1 cycle later status 0
//    -> downstream sees payload, o_ready[0] pulses 1 cycle, o_ready[1]=0.
//  2 req0,req1 both valid continuously, ready always 1 -> grants alternate 0,1,0,1; no starvation.
//  3 N=3, pointer at 2, only req0 valid -> wrap, grant 0; pointer then 1.
//  4 TIMEOUT_CYCLES=4, ready held 0 -> o_ready pulses on 4th BUSY cycle, status 2'b10, data 0.
//  5 TIMEOUT_CYCLES=4, ready on 4th BUSY cycle, status 2'b01 -> host gets 2'b01, not SLVERR.
//  6 i_rst for 1 cycle mid BUSY -> valid drops next cycle, no o_ready, next grant from port 0.

Source files
------------

// File: rtl/rggen_register_access_arbiter_pkg.sv
// Shared types and constants for the register access arbiter and its round-robin picker.
package rggen_register_access_arbiter_pkg;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY = 2'b01;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;

    // (base + offset) mod modulus, for operands already below modulus.
    function automatic int wrap_add(int base, int offset, int modulus);
        int sum;
        sum = base + offset;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rggen_register_access_arbiter_rr.sv
// Round-robin picker: first set request at or after the pointer, wrapping to 0.
module rggen_register_access_arbiter_rr
    import rggen_register_access_arbiter_pkg::*;
#(
    parameter int REQUESTERS  = 2,
    parameter int INDEX_WIDTH = 1
) (
    input  logic [REQUESTERS-1:0]  request,
    input  logic [INDEX_WIDTH-1:0] pointer,
    output logic [REQUESTERS-1:0]  grant,
    output logic [INDEX_WIDTH-1:0] index
);

    logic [INDEX_WIDTH-1:0] candidate;

    // Scan from the farthest offset down so the nearest hit is the last one written.
    always_comb begin
        index     = '0;
        candidate = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            candidate = INDEX_WIDTH'(wrap_add(int'(pointer), i, REQUESTERS));
            if (request[candidate]) begin
                index = candidate;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_grant
            assign grant[gi] = request[gi] && (index == INDEX_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Shares one register bus among several hosts: round-robin grant held until the
// register block responds, with an optional timeout that answers SLVERR.
module rggen_register_access_arbiter
    import rggen_register_access_arbiter_pkg::*;
#(
    parameter int REQUESTERS     = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [REQUESTERS-1:0]           i_valid,
    input  logic [2*REQUESTERS-1:0]         i_access,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS*BUS_WIDTH-1:0] i_write_data,
    input  logic [REQUESTERS*BUS_WIDTH-1:0] i_strobe,
    output logic [REQUESTERS-1:0]           o_ready,
    output logic [2*REQUESTERS-1:0]         o_status,
    output logic [REQUESTERS*BUS_WIDTH-1:0] o_read_data,
    output logic                            o_register_valid,
    output logic [1:0]                      o_register_access,
    output logic [ADDRESS_WIDTH-1:0]        o_register_address,
    output logic [BUS_WIDTH-1:0]            o_register_write_data,
    output logic [BUS_WIDTH-1:0]            o_register_strobe,
    input  logic                            i_register_ready,
    input  logic [1:0]                      i_register_status,
    input  logic [BUS_WIDTH-1:0]            i_register_read_data
);

    localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    state_t                  state_reg;
    logic [INDEX_WIDTH-1:0]  index_reg;
    logic [REQUESTERS-1:0]   grant_reg;
    logic [INDEX_WIDTH-1:0]  pointer_reg;
    logic [INDEX_WIDTH-1:0]  pointer_next;
    logic [INDEX_WIDTH-1:0]  rr_index;
    logic [REQUESTERS-1:0]   rr_grant;
    logic                    busy;
    logic                    timeout;
    logic                    response;
    logic [1:0]              response_status;
    logic [BUS_WIDTH-1:0]    response_data;

    logic [1:0]              access_array  [REQUESTERS];
    logic [ADDRESS_WIDTH-1:0] address_array [REQUESTERS];
    logic [BUS_WIDTH-1:0]    write_data_array [REQUESTERS];
    logic [BUS_WIDTH-1:0]    strobe_array  [REQUESTERS];

    rggen_register_access_arbiter_rr #(
        .REQUESTERS  (REQUESTERS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_rr (
        .request (i_valid),
        .pointer (pointer_reg),
        .grant   (rr_grant),
        .index   (rr_index)
    );

    assign busy         = (state_reg == STATE_BUSY);
    assign pointer_next = (index_reg == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : index_reg + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= STATE_IDLE;
            index_reg   <= '0;
            grant_reg   <= '0;
            pointer_reg <= '0;
        end else begin
            case (state_reg)
                STATE_IDLE: begin
                    if (|i_valid) begin
                        state_reg <= STATE_BUSY;
                        index_reg <= rr_index;
                        grant_reg <= rr_grant;
                    end
                end
                STATE_BUSY: begin
                    if (response) begin
                        state_reg   <= STATE_IDLE;
                        pointer_reg <= pointer_next;
                    end
                end
                default: state_reg <= STATE_IDLE;
            endcase
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
            logic [COUNT_WIDTH-1:0] count_reg;

            // Idle keeps the counter at zero, so it is already clear on BUSY entry.
            always_ff @(posedge i_clk) begin
                if (i_rst || !busy) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign timeout = busy && (count_reg == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // A real downstream response takes priority over a coincident timeout.
    assign response        = busy && (i_register_ready || timeout);
    assign response_status = i_register_ready ? i_register_status : STATUS_SLVERR;
    assign response_data   = i_register_ready ? i_register_read_data : '0;

    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_port
            assign access_array[gi]     = i_access[gi*2 +: 2];
            assign address_array[gi]    = i_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign write_data_array[gi] = i_write_data[gi*BUS_WIDTH +: BUS_WIDTH];
            assign strobe_array[gi]     = i_strobe[gi*BUS_WIDTH +: BUS_WIDTH];

            assign o_ready[gi]                          = response && grant_reg[gi];
            assign o_status[gi*2 +: 2]                  = (response && grant_reg[gi]) ? response_status : STATUS_OKAY;
            assign o_read_data[gi*BUS_WIDTH +: BUS_WIDTH] = (response && grant_reg[gi]) ? response_data : '0;
        end
    endgenerate

    assign o_register_valid      = busy;
    assign o_register_access     = access_array[index_reg];
    assign o_register_address    = address_array[index_reg];
    assign o_register_write_data = write_data_array[index_reg];
    assign o_register_strobe     = strobe_array[index_reg];

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Directed and randomized checks of the register access arbiter against a
// cycle-level reference model (3 hosts, timeout of 4 BUSY cycles).
module tb_rggen_register_access_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [2*N-1:0]    access;
    logic [N*AW-1:0]   address;
    logic [N*BW-1:0]   wdata;
    logic [N*BW-1:0]   strobe;
    logic [N-1:0]      ready;
    logic [2*N-1:0]    status;
    logic [N*BW-1:0]   rdata;
    logic              reg_valid;
    logic [1:0]        reg_access;
    logic [AW-1:0]     reg_address;
    logic [BW-1:0]     reg_wdata;
    logic [BW-1:0]     reg_strobe;
    logic              reg_ready;
    logic [1:0]        reg_status;
    logic [BW-1:0]     reg_rdata;

    always #5 clk = ~clk;

    rggen_register_access_arbiter #(
        .REQUESTERS     (N),
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_valid               (valid),
        .i_access              (access),
        .i_address             (address),
        .i_write_data          (wdata),
        .i_strobe              (strobe),
        .o_ready               (ready),
        .o_status              (status),
        .o_read_data           (rdata),
        .o_register_valid      (reg_valid),
        .o_register_access     (reg_access),
        .o_register_address    (reg_address),
        .o_register_write_data (reg_wdata),
        .o_register_strobe     (reg_strobe),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_rdata)
    );

    // Host-side request state.
    bit            v  [N];
    logic [1:0]    a  [N];
    logic [AW-1:0] ad [N];
    logic [BW-1:0] wd [N];
    logic [BW-1:0] sb [N];
    bit            auto_drop;

    // Reference model state.
    bit m_busy;
    int m_grant;
    int m_ptr;
    int m_age;

    // Per-cycle observations for directed checks.
    int            resp_port;
    logic          snap_valid;
    logic [AW-1:0] snap_addr;
    logic [BW-1:0] snap_wdata;
    logic [N-1:0]  snap_ready;
    logic [1:0]    snap_status;
    logic [BW-1:0] snap_rdata;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at negedge against the model, advance the model.
    task automatic step();
        logic [N-1:0]    exp_ready;
        logic [2*N-1:0]  exp_status;
        logic [N*BW-1:0] exp_rdata;
        bit              resp;
        int              g;
        for (int p = 0; p < N; p++) begin
            valid[p]              = v[p];
            access[2*p +: 2]      = a[p];
            address[AW*p +: AW]   = ad[p];
            wdata[BW*p +: BW]     = wd[p];
            strobe[BW*p +: BW]    = sb[p];
        end
        @(negedge clk);
        g          = m_grant;
        exp_ready  = '0;
        exp_status = '0;
        exp_rdata  = '0;
        resp       = m_busy && (reg_ready || m_age == TO - 1);
        if (resp) begin
            exp_ready[g]          = 1'b1;
            exp_status[2*g +: 2]  = reg_ready ? reg_status : 2'b10;
            exp_rdata[BW*g +: BW] = reg_ready ? reg_rdata : '0;
        end
        check("reg_valid", reg_valid, m_busy);
        if (m_busy) begin
            check("payload", {reg_access, reg_address, reg_wdata, reg_strobe}, {a[g], ad[g], wd[g], sb[g]});
        end
        check("ready", ready, exp_ready);
        check("status", status, exp_status);
        check("read_data", rdata, exp_rdata);

        resp_port   = resp ? g : -1;
        snap_valid  = reg_valid;
        snap_addr   = reg_address;
        snap_wdata  = reg_wdata;
        snap_ready  = ready;
        snap_status = status[2*g +: 2];
        snap_rdata  = rdata[BW*g +: BW];

        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_age  = 0;
        end else if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (v[(m_ptr + k) % N]) begin
                    m_grant = (m_ptr + k) % N;
                    m_busy  = 1;
                end
            end
            m_age = 0;
        end else if (resp) begin
            m_busy = 0;
            m_ptr  = (g + 1) % N;
        end else begin
            m_age++;
        end
        if (resp && auto_drop && !rst) begin
            v[g] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_request(input int p);
        v[p]  = 1;
        a[p]  = 2'($urandom_range(0, 3));
        ad[p] = AW'($urandom_range(0, 255));
        wd[p] = $urandom;
        sb[p] = $urandom;
    endtask

    initial begin
        int seq [$];
        int busy_cycles;

        for (int p = 0; p < N; p++) begin
            v[p] = 0; a[p] = '0; ad[p] = '0; wd[p] = '0; sb[p] = '0;
        end
        auto_drop  = 1;
        reg_ready  = 0;
        reg_status = 2'b00;
        reg_rdata  = '0;
        m_busy = 0; m_grant = 0; m_ptr = 0; m_age = 0;

        rst = 1;
        @(posedge clk);
        #1;
        step();
        check("reset_valid", snap_valid, 1'b0);
        check("reset_ready", snap_ready, 3'b000);
        rst = 0;

        // Single write from port 0, answered one BUSY cycle late.
        v[0] = 1; a[0] = 2'b01; ad[0] = 8'h04; wd[0] = 32'hA5A5A5A5; sb[0] = 32'hFFFFFFFF;
        step();
        check("t1_idle_valid", snap_valid, 1'b0);
        step();
        check("t1_busy_valid", snap_valid, 1'b1);
        check("t1_addr", snap_addr, 8'h04);
        check("t1_wdata", snap_wdata, 32'hA5A5A5A5);
        check("t1_no_early_ready", snap_ready, 3'b000);
        reg_ready = 1; reg_status = 2'b00; reg_rdata = 32'h1234_5678;
        step();
        check("t1_ready", snap_ready, 3'b001);
        reg_ready = 0;
        step();
        check("t1_ready_gone", snap_ready, 3'b000);
        $display("[TB] txn t1 port0 write addr=04 done");

        // Ports 0 and 1 continuously valid with an always-ready block: grants alternate.
        auto_drop = 0;
        new_request(0);
        new_request(1);
        reg_ready = 1;
        for (int i = 0; i < 8; i++) begin
            reg_status = 2'($urandom_range(0, 3));
            reg_rdata  = $urandom;
            step();
            if (resp_port != -1) begin
                seq.push_back(resp_port);
                $display("[TB] txn t2 grant port%0d", resp_port);
            end
        end
        check("t2_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size(); i++) begin
            check("t2_alternate", 32'(seq[i]), 32'((1 + i) % 2));
        end
        v[0] = 0; v[1] = 0;
        auto_drop = 1;
        reg_ready = 0;
        step();

        // Move the pointer to 2, then only port 0 requests: pick wraps to 0.
        new_request(1);
        step();
        reg_ready = 1;
        step();
        check("t3_port1", 32'(resp_port), 32'd1);
        reg_ready = 0;
        new_request(0);
        step();
        reg_ready = 1;
        step();
        check("t3_wrap_port0", 32'(resp_port), 32'd0);
        reg_ready = 0;
        new_request(0); new_request(1); new_request(2);
        step();
        reg_ready = 1;
        step();
        check("t3_next_port1", 32'(resp_port), 32'd1);
        reg_ready = 0;
        v[0] = 0; v[2] = 0;
        step();
        $display("[TB] txn t3 wrap grant checks done");

        // Hung block: SLVERR with zero data on the 4th BUSY cycle.
        new_request(2);
        reg_rdata = 32'hDEAD_BEEF;
        step();
        busy_cycles = 0;
        for (int i = 1; i <= 10 && busy_cycles == 0; i++) begin
            step();
            if (resp_port != -1) begin
                busy_cycles = i;
            end
        end
        check("t4_timeout_cycle", 32'(busy_cycles), 32'd4);
        check("t4_status", snap_status, 2'b10);
        check("t4_data", snap_rdata, 32'h0);
        check("t4_port2_ready", snap_ready, 3'b100);
        $display("[TB] txn t4 timeout after %0d busy cycles", busy_cycles);

        // Real response on the timeout cycle wins.
        new_request(0);
        step();
        repeat (3) step();
        reg_ready = 1; reg_status = 2'b01; reg_rdata = 32'hCAFE_F00D;
        step();
        check("t5_status", snap_status, 2'b01);
        check("t5_data", snap_rdata, 32'hCAFE_F00D);
        check("t5_ready", snap_ready, 3'b001);
        reg_ready = 0;
        $display("[TB] txn t5 ready beats timeout");

        // Reset in BUSY: no response, pointer back to 0.
        new_request(1);
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        v[1] = 0;
        new_request(0);
        new_request(2);
        step();
        check("t6_valid_dropped", snap_valid, 1'b0);
        check("t6_no_ready", snap_ready, 3'b000);
        reg_ready = 1;
        step();
        check("t6_grant_port0", 32'(resp_port), 32'd0);
        reg_ready = 0;
        v[2] = 0;
        step();
        $display("[TB] txn t6 reset in busy");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!v[p] && $urandom_range(0, 2) == 0) begin
                    new_request(p);
                end
            end
            reg_ready  = ($urandom_range(0, 2) == 0);
            reg_status = 2'($urandom_range(0, 3));
            reg_rdata  = $urandom;
            step();
            if (resp_port != -1) begin
                $display("[TB] txn rand cycle=%0d port%0d status=%0b", c, resp_port, snap_status);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
